// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, RGB pixel struct, colour-bar table.
// Used by vga_timing_gen and vga_video_out through a wildcard import.
// No logic here, only constants, types and one lookup helper.
package vga_pkg;

  // 640x480@60 reference timing (pixels / lines)
  localparam int VGA_H_ACTIVE   = 640;
  localparam int VGA_H_FP       = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BP       = 48;
  localparam int VGA_V_ACTIVE   = 480;
  localparam int VGA_V_FP       = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BP       = 33;
  localparam int VGA_COLOR_BITS = 4;

  // Pixel word at the reference channel width, laid out as {R,G,B}
  typedef struct packed {
    logic [VGA_COLOR_BITS-1:0] r;
    logic [VGA_COLOR_BITS-1:0] g;
    logic [VGA_COLOR_BITS-1:0] b;
  } rgb_t;

  // Colour bars left to right, one {R,G,B} on/off triple per bar:
  // white, yellow, cyan, green, magenta, red, blue, black (index 0 is the LSB entry)
  localparam logic [7:0][2:0] BAR_TBL = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    return BAR_TBL[idx];
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel prescaler, X/Y raster counters, VideoOn and raw (active-high) sync flags.
// tick_o is registered; position outputs change on the Clk edge that ends a tick.
// No backpressure: free-running raster, only reset can stop it.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PIX_DIV  = 2,
  parameter int CW       = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          tick_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          video_on_o,
  output logic          hs_raw_o,
  output logic          vs_raw_o,
  output logic          frame_start_o,
  output logic          line_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  // Next state: prescaler wraps at PIX_DIV-1 and raises the tick for the following cycle;
  // counters advance on the edge that closes a tick cycle.
  always_comb begin
    presc_d = presc_q + 1'b1;
    tick_d  = 1'b0;
    if (presc_q == PW'(PIX_DIV - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
    x_d = x_q;
    y_d = y_q;
    if (tick_q) begin
      if (x_q == CW'(H_TOTAL - 1)) begin
        x_d = '0;
        if (y_q == CW'(V_TOTAL - 1)) y_d = '0;
        else                         y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Raster state registers; reset restarts the frame at (0,0) with the prescaler cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign tick_o        = tick_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign video_on_o    = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
  assign hs_raw_o      = (x_q >= CW'(H_ACTIVE + H_FP)) && (x_q <= CW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_raw_o      = (y_q >= CW'(V_ACTIVE + V_FP)) && (y_q <= CW'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign line_start_o  = tick_q && (x_q == '0);
  assign frame_start_o = tick_q && (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/vga_video_out.sv
// VGA output stage: raster timing, PIPE_LAT-tick alignment line, registered pins (PIPE_LAT+1 ticks).
// Optional colour-bar generator enabled by defining VGA_VIDEO_OUT_TESTPAT_EN (adds TestPattern input).
// No backpressure: pixel source must return RGB exactly PIPE_LAT ticks after the position.
module vga_video_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_BITS = VGA_COLOR_BITS,
  parameter int PIX_DIV    = 2,
  parameter int PIPE_LAT   = 1,
  parameter int CW         = 11
) (
  input  logic                    Clk,
  input  logic                    Reset,
`ifdef VGA_VIDEO_OUT_TESTPAT_EN
  input  logic                    TestPattern,
`endif
  input  logic [3*COLOR_BITS-1:0] RGB,
  output logic                    VideoOn,
  output logic                    PixelTick,
  output logic [CW-1:0]           PixelX,
  output logic [CW-1:0]           PixelY,
  output logic                    FrameStart,
  output logic                    LineStart,
  output logic [COLOR_BITS-1:0]   VGA_R,
  output logic [COLOR_BITS-1:0]   VGA_G,
  output logic [COLOR_BITS-1:0]   VGA_B,
  output logic                    VGA_HS,
  output logic                    VGA_VS
);

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } pix_t;

  logic hs_raw, vs_raw;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .CW(CW)
  ) u_timing (
    .clk_i        (Clk),
    .rst_ni       (Reset),
    .tick_o       (PixelTick),
    .x_o          (PixelX),
    .y_o          (PixelY),
    .video_on_o   (VideoOn),
    .hs_raw_o     (hs_raw),
    .vs_raw_o     (vs_raw),
    .frame_start_o(FrameStart),
    .line_start_o (LineStart)
  );

  // Stage word carries {VideoOn, HS, VS} and, for the bar generator, the X position.
`ifdef VGA_VIDEO_OUT_TESTPAT_EN
  localparam int SW = CW + 3;
  logic [SW-1:0] cur_stage;
  assign cur_stage = {VideoOn, hs_raw, vs_raw, PixelX};
`else
  localparam int SW = 3;
  logic [SW-1:0] cur_stage;
  assign cur_stage = {VideoOn, hs_raw, vs_raw};
`endif

  logic [SW-1:0] dly_stage;

  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign dly_stage = cur_stage;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0][SW-1:0] line_q;
      // Delay line that matches the pixel source latency; blank/inactive out of reset.
      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          line_q <= '0;
        end else if (PixelTick) begin
          line_q[0] <= cur_stage;
          for (int i = 1; i < PIPE_LAT; i++) line_q[i] <= line_q[i-1];
        end
      end
      assign dly_stage = line_q[PIPE_LAT-1];
    end
  endgenerate

  logic dly_von, dly_hs, dly_vs;
  assign dly_von = dly_stage[SW-1];
  assign dly_hs  = dly_stage[SW-2];
  assign dly_vs  = dly_stage[SW-3];

  pix_t rgb_in, src_pix;
  assign rgb_in = RGB;

`ifdef VGA_VIDEO_OUT_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [CW-1:0] bar_idx_full;
  logic [2:0]    bar_bits;
  // Colour bar keyed on the delayed X so the bars share the source's latency.
  always_comb begin
    bar_idx_full = dly_stage[CW-1:0] / CW'(BAR_W);
    bar_bits     = bar_color((bar_idx_full > CW'(7)) ? 3'd7 : bar_idx_full[2:0]);
    src_pix      = rgb_in;
    if (TestPattern) begin
      src_pix.r = {COLOR_BITS{bar_bits[2]}};
      src_pix.g = {COLOR_BITS{bar_bits[1]}};
      src_pix.b = {COLOR_BITS{bar_bits[0]}};
    end
  end
`else
  assign src_pix = rgb_in;
`endif

  pix_t pix_q;
  logic hs_q, vs_q;

  // Pin registers: colour forced black outside the visible area, syncs mapped to polarity.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pix_q <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else if (PixelTick) begin
      pix_q <= dly_von ? src_pix : '0;
      hs_q  <= dly_hs ? HS_POL : ~HS_POL;
      vs_q  <= dly_vs ? VS_POL : ~VS_POL;
    end
  end

  assign VGA_R  = pix_q.r;
  assign VGA_G  = pix_q.g;
  assign VGA_B  = pix_q.b;
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;

endmodule

// File: doc/vga_video_out.md
VGA_VIDEO_OUT -- requirements
Module: vga_video_out

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (lines); HS_POL 0 and VS_POL 0, active sync level; COLOR_BITS 4 bits per channel; PIX_DIV 2 Clk cycles per pixel (>=1); PIPE_LAT 1 pixel-source latency in pixel ticks (0..7); CW 11 coordinate width.
REQ-002 Clk, input, 1, system clock; all state on rising edge.
REQ-003 Reset, input, 1, asynchronous active-low reset.
REQ-004 VideoOn, output, 1, current position (PixelX, PixelY) is visible.
REQ-005 PixelTick, output, 1, one-Clk pixel-advance strobe.
REQ-006 PixelX and PixelY, output, CW each, current counter position, including the blanking region.
REQ-007 FrameStart, output, 1, one-tick pulse when position is (0,0); LineStart, output, 1, pulse when PixelX==0.
REQ-008 RGB, input, 3*COLOR_BITS, pixel data as {R,G,B} returned by the source.
REQ-009 VGA_R, VGA_G and VGA_B, output, COLOR_BITS each; VGA_HS and VGA_VS, output, 1 each.

Function
REQ-010 A prescaler SHALL assert PixelTick for one Clk every PIX_DIV cycles; with PIX_DIV==1 PixelTick SHALL be constantly 1 after reset.
REQ-011 PixelX SHALL increment on PixelTick and wrap from H_TOTAL-1 (the sum of H_*) to 0; PixelY SHALL increment only on that wrap and wrap from V_TOTAL-1 to 0.
REQ-012 VideoOn SHALL be (PixelX < H_ACTIVE) && (PixelY < V_ACTIVE), combinational from the counters.
REQ-013 Raw HS SHALL be active when PixelX is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw VS SHALL follow the same rule on PixelY with the V_* parameters.
REQ-014 RGB for position (x,y) SHALL be sampled on the PIPE_LAT-th PixelTick after PixelX/PixelY first present (x,y); with PIPE_LAT==0 it is sampled on the same tick.
REQ-015 VideoOn, raw HS and raw VS SHALL pass through a PIPE_LAT-stage shift register advanced only on PixelTick, keeping them aligned with the sampled RGB.
REQ-016 All VGA_* outputs SHALL be registered, updated on PixelTick; total latency from position to pins is PIPE_LAT+1 ticks.
REQ-017 VGA_R/G/B SHALL be 0 whenever the delayed VideoOn is 0, regardless of RGB.
REQ-018 VGA_HS SHALL equal HS_POL when the delayed HS is active and ~HS_POL otherwise; VGA_VS follows the same rule with VS_POL.
REQ-019 Between ticks, all outputs and pipeline stages SHALL hold their values.

Reset
REQ-020 While Reset==0: prescaler, PixelX and PixelY SHALL be 0; all pipeline stages SHALL be blank/inactive; VGA_R/G/B SHALL be 0; VGA_HS SHALL be ~HS_POL and VGA_VS ~VS_POL; FrameStart, LineStart and PixelTick SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL take effect immediately; after release, the first PixelTick SHALL occur PIX_DIV cycles later, with the frame restarting at (0,0).

Configuration
REQ-022 With VGA_VIDEO_OUT_TESTPAT_EN defined, an input TestPattern (1 bit) SHALL replace sampled RGB with 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black; each channel all-ones or zero), keyed on the delayed PixelX and keeping identical latency.
REQ-023 Without VGA_VIDEO_OUT_TESTPAT_EN, the TestPattern port and the bar logic SHALL be absent.

Structure
REQ-024 Package vga_pkg SHALL hold the 640x480@60 timing constants, an RGB struct typedef parameterised by COLOR_BITS, and the colour-bar table.
REQ-025 Sub-module vga_timing_gen SHALL contain the prescaler, counters, VideoOn and raw syncs; vga_video_out SHALL add the delay line and output registers.

Verification
REQ-026 Bench timing: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), PIX_DIV=2, PIPE_LAT=1, polarities 0.
REQ-027 Tick/wrap: free run -> PixelTick every 2nd Clk; PixelX 13->0 with PixelY+1; (13,7)->(0,0) with FrameStart=1 for one tick.
REQ-028 Sync: VGA_HS low for exactly 3 ticks, starting 2 ticks (PIPE_LAT+1) after PixelX reaches 10; VGA_VS low for 2 lines.
REQ-029 Latency: source returns RGB=12'hA5C one tick late -> VGA_R/G/B = A/5/C on the tick after sampling; RGB=12'hFFF during blanking -> VGA_R/G/B = 0.
REQ-030 Reset mid-line at PixelX=5 -> VGA_* = 0, HS/VS = 1 at once; after release, first tick lands at (0,0).
REQ-031 PIX_DIV=1, PIPE_LAT=0 -> PixelTick constantly 1; output for (x,y) appears 1 Clk later; with TESTPAT_EN and TestPattern=1 at PixelX=0 -> FFF.
